sync_fifo: RTL and testbench

Parametrised synchronous FIFO built on a dual-port register-array memory, with a registered read port, occupancy count and error pulses. Generalises the team's single-clock RAM into a flow-controlled buffer between a producer and consumer in the same clock domain. Used wherever a datapath stage needs elastic buffering of up to `Depth` words.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 37 +++
 rtl/sync_fifo.sv | 119 +++++++++++
 tb/tb_sync_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: the pointer-width helper
// and the values the status outputs take while reset is asserted.
package sync_fifo_pkg;

    // Pointers carry one extra wrap bit above the memory address bits
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam logic RST_EMPTY = 1'b1;
    localparam logic RST_FULL  = 1'b0;
    localparam logic RST_VALID = 1'b0;
    localparam logic RST_PULSE = 1'b0;

endpackage

// File: rtl/sync_fifo_mem.sv
// Width x Depth dual-port register array. Storage is never reset; only the
// registered read port clears so the FIFO read data starts at zero.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] waddr,
    input  logic [Width-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(Depth)-1:0] raddr,
    output logic [Width-1:0]         rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-address read and write returns the old word, which is what the
    // full FIFO needs when it pops and pushes in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read port, occupancy count and
// overflow/underflow pulses. Define SYNC_FIFO_ALMOST_EN for almost flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int Width          = 8,
    parameter int Depth          = 16,
    parameter int AlmostFullThr  = Depth - 2,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wrEn,
    input  logic [Width-1:0]             wrData,
    input  logic                         rdEn,
    output logic [Width-1:0]             rdData,
    output logic                         rdValid,
    output logic                         full,
    output logic                         empty,
    output logic [ptr_width(Depth)-1:0]  count,
`ifdef SYNC_FIFO_ALMOST_EN
    output logic                         almost_full,
    output logic                         almost_empty,
`endif
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = ptr_width(Depth);

    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr_nxt;
    logic [PtrW-1:0] rd_ptr_nxt;
    logic [PtrW-1:0] count_nxt;
    logic            wr_acc;
    logic            rd_acc;
    logic            full_nxt;
    logic            empty_nxt;

    // Acceptance uses only registered flags, so no input reaches an output
    // without passing through a flop.
    always_comb begin
        rd_acc     = rdEn && !empty;
        wr_acc     = wrEn && (!full || rd_acc);
        wr_ptr_nxt = wr_ptr + PtrW'(wr_acc);
        rd_ptr_nxt = rd_ptr + PtrW'(rd_acc);
        count_nxt  = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + PtrW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - PtrW'(1);
        end
        empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt  = (wr_ptr_nxt[PtrW-1] != rd_ptr_nxt[PtrW-1]) &&
                    (wr_ptr_nxt[AddrW-1:0] == rd_ptr_nxt[AddrW-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= RST_EMPTY;
            full      <= RST_FULL;
            rdValid   <= RST_VALID;
            overflow  <= RST_PULSE;
            underflow <= RST_PULSE;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            empty     <= empty_nxt;
            full      <= full_nxt;
            rdValid   <= rd_acc;
            overflow  <= wrEn && !wr_acc;
            underflow <= rdEn && !rd_acc;
        end
    end

`ifdef SYNC_FIFO_ALMOST_EN
    logic almost_full_nxt;
    logic almost_empty_nxt;

    always_comb begin
        almost_full_nxt  = (int'(count_nxt) >= AlmostFullThr);
        almost_empty_nxt = (int'(count_nxt) <= AlmostEmptyThr);
    end

    // Thresholds are applied to the next count so the flags line up with count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full  <= RST_FULL;
            almost_empty <= RST_EMPTY;
        end else begin
            almost_full  <= almost_full_nxt;
            almost_empty <= almost_empty_nxt;
        end
    end
`else
    localparam int unused_thr_sum = AlmostFullThr + AlmostEmptyThr;
`endif

    sync_fifo_mem #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[AddrW-1:0]),
        .wdata (wrData),
        .re    (rd_acc),
        .raddr (rd_ptr[AddrW-1:0]),
        .rdata (rdData)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed and random traffic compared
// against a queue-based reference model of the FIFO.
module tb_sync_fifo;

    localparam int W   = 8;
    localparam int D   = 16;
    localparam int AFT = D - 2;
    localparam int AET = 2;
    localparam int CW  = $clog2(D) + 1;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          wrEn   = 1'b0;
    logic          rdEn   = 1'b0;
    logic [W-1:0]  wrData = '0;
    logic [W-1:0]  rdData;
    logic          rdValid;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
`ifdef SYNC_FIFO_ALMOST_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    sync_fifo #(
        .Width          (W),
        .Depth          (D),
        .AlmostFullThr  (AFT),
        .AlmostEmptyThr (AET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wrEn         (wrEn),
        .wrData       (wrData),
        .rdEn         (rdEn),
        .rdData       (rdData),
        .rdValid      (rdValid),
        .full         (full),
        .empty        (empty),
        .count        (count),
`ifdef SYNC_FIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] exp_rd  = '0;
    logic         exp_vld = 1'b0;
    logic         exp_ovf = 1'b0;
    logic         exp_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        check({ctx, ".count"},     32'(count),     32'(n));
        check({ctx, ".full"},      32'(full),      32'(n == D));
        check({ctx, ".empty"},     32'(empty),     32'(n == 0));
        check({ctx, ".rdValid"},   32'(rdValid),   32'(exp_vld));
        check({ctx, ".rdData"},    32'(rdData),    32'(exp_rd));
        check({ctx, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check({ctx, ".underflow"}, 32'(underflow), 32'(exp_unf));
`ifdef SYNC_FIFO_ALMOST_EN
        check({ctx, ".almost_full"},  32'(almost_full),  32'(n >= AFT));
        check({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= AET));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd  = '0;
        exp_vld = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    // One clock of traffic: predict with the queue model, clock, then compare.
    task automatic step(input string ctx, input logic we, input logic [W-1:0] wd, input logic re);
        bit rd_ok;
        bit wr_ok;
        wrEn   = we;
        wrData = wd;
        rdEn   = re;
        rd_ok  = re && (q.size() > 0);
        wr_ok  = we && ((q.size() < D) || rd_ok);
        if (rd_ok) exp_rd = q.pop_front();
        if (wr_ok) q.push_back(wd);
        exp_vld = rd_ok;
        exp_ovf = we && !wr_ok;
        exp_unf = re && !rd_ok;
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        rdEn = 1'b0;
        check_all(ctx);
    endtask

    task automatic random_steps(input string ctx, input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++) begin
            step(ctx, ($urandom_range(0, 99) < pw), W'($urandom), ($urandom_range(0, 99) < pr));
        end
    endtask

    initial begin
        // Power-up reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held");
        rst = 1'b0;
        check_all("reset_rel");
        step("idle", 1'b0, '0, 1'b0);
        step("idle", 1'b0, '0, 1'b0);

        // Fill to full, then overflow
        for (int i = 0; i < D; i++) step("fill", 1'b1, W'(i), 1'b0);
        check("fill.full_at_16", 32'(full), 32'd1);
        step("ovf", 1'b1, 8'hAA, 1'b0);
        check("ovf.pulse", 32'(overflow), 32'd1);
        step("ovf_clear", 1'b0, '0, 1'b0);

        // Drain in order, then underflow
        for (int i = 0; i < D; i++) begin
            step("drain", 1'b0, '0, 1'b1);
            check("drain.order", 32'(rdData), 32'(i));
        end
        step("unf", 1'b0, '0, 1'b1);
        check("unf.hold", 32'(rdData), 32'h0F);
        check("unf.pulse", 32'(underflow), 32'd1);

        // Simultaneous read and write on a full FIFO
        for (int i = 0; i < D; i++) step("refill", 1'b1, W'(i), 1'b0);
        step("full_rw", 1'b1, 8'h55, 1'b1);
        check("full_rw.rdData", 32'(rdData), 32'h00);
        for (int i = 0; i < D; i++) step("full_rw_drain", 1'b0, '0, 1'b1);
        check("full_rw.last", 32'(rdData), 32'h55);

        // Simultaneous read and write on an empty FIFO
        step("empty_rw", 1'b1, 8'h33, 1'b1);
        check("empty_rw.unf", 32'(underflow), 32'd1);
        step("empty_rw_read", 1'b0, '0, 1'b1);
        check("empty_rw.data", 32'(rdData), 32'h33);

        // Interleaved traffic wrapping the pointers, then reset mid-stream
        random_steps("wrap", 140, 70, 60);
        wrEn = 1'b1;
        rdEn = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        wrEn = 1'b0;
        rdEn = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_mid_held");
        rst = 1'b0;
        step("post_rst_wr", 1'b1, 8'h7E, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1);
        check("post_rst.data", 32'(rdData), 32'h7E);

        // Longer random traffic alternating fill-heavy and drain-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            random_steps("rand", 80, (ph % 2 == 0) ? 80 : 25, (ph % 2 == 0) ? 25 : 80);
        end
        random_steps("rand_bal", 200, 50, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
